triloc_seq: RTL and testbench

Sequencing controller for the trilateration datapath. It collects three anchor coordinate words (A, B, C) and one packed range word from four independent valid/ready requesters, in any order. It then holds the operands stable on an internally instantiated `TriLoc` core for a fixed multicycle window, registers the `{xM, yM}` result, and offers it on a valid/ready output. It sits between the party input channels and the result consumer, and lets the combinational core be timed as a multicycle path.

---
 rtl/triloc_seq_if.sv | 41 ++++
 rtl/TriLoc.sv | 59 +++++
 rtl/triloc_seq.sv | 135 +++++++++++++
 tb/tb_triloc_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/triloc_seq_if.sv
// triloc_seq_if: handshake bundle between the four operand requesters,
// the result consumer and triloc_seq.
//   p0..p2 : anchor A/B/C words {x, y}, each field signed N bits
//   p3     : range word {rA, rB, rC}, each field signed N+1 bits
//   o_*    : result {xM, yM}, each field signed N+4 bits
// master = requesters/consumer side, slave = triloc_seq side.
interface triloc_seq_if #(
    parameter int unsigned N = 8
);
    logic               p0_valid;
    logic               p0_ready;
    logic [2*N-1:0]     p0_data;
    logic               p1_valid;
    logic               p1_ready;
    logic [2*N-1:0]     p1_data;
    logic               p2_valid;
    logic               p2_ready;
    logic [2*N-1:0]     p2_data;
    logic               p3_valid;
    logic               p3_ready;
    logic [3*N+2:0]     p3_data;
    logic               o_valid;
    logic               o_ready;
    logic [2*N+7:0]     o_data;

    modport master (
        output p0_valid, p0_data, p1_valid, p1_data,
        output p2_valid, p2_data, p3_valid, p3_data,
        output o_ready,
        input  p0_ready, p1_ready, p2_ready, p3_ready,
        input  o_valid, o_data
    );

    modport slave (
        input  p0_valid, p0_data, p1_valid, p1_data,
        input  p2_valid, p2_data, p3_valid, p3_data,
        input  o_ready,
        output p0_ready, p1_ready, p2_ready, p3_ready,
        output o_valid, o_data
    );
endinterface

// File: rtl/TriLoc.sv
// TriLoc: combinational 2-D trilateration core.
// Subtracting the circle equations of A/B and B/C gives two linear
// equations, solved by Cramer's rule; quotients truncate toward zero and
// are then reduced to N+4 bits. Coincident/collinear anchors (zero
// determinant) yield {0, 0}.
//   i_xa..i_yc : anchor coordinates, signed N bits
//   i_ra..i_rc : ranges, signed N+1 bits
//   o_xm, o_ym : position, signed N+4 bits
module TriLoc #(
    parameter int unsigned N = 8
) (
    input  logic signed [N-1:0] i_xa,
    input  logic signed [N-1:0] i_ya,
    input  logic signed [N-1:0] i_xb,
    input  logic signed [N-1:0] i_yb,
    input  logic signed [N-1:0] i_xc,
    input  logic signed [N-1:0] i_yc,
    input  logic signed [N:0]   i_ra,
    input  logic signed [N:0]   i_rb,
    input  logic signed [N:0]   i_rc,
    output logic signed [N+3:0] o_xm,
    output logic signed [N+3:0] o_ym
);
    localparam int unsigned W  = 4 * N + 16;
    localparam int unsigned RW = N + 4;

    logic signed [W-1:0] w_xa, w_ya, w_xb, w_yb, w_xc, w_yc;
    logic signed [W-1:0] w_ra, w_rb, w_rc;
    logic signed [W-1:0] w_a1, w_b1, w_c1, w_a2, w_b2, w_c2;
    logic signed [W-1:0] w_det, w_xn, w_yn;

    // Sign-extend everything to a width that cannot overflow.
    assign w_xa = W'(i_xa);
    assign w_ya = W'(i_ya);
    assign w_xb = W'(i_xb);
    assign w_yb = W'(i_yb);
    assign w_xc = W'(i_xc);
    assign w_yc = W'(i_yc);
    assign w_ra = W'(i_ra);
    assign w_rb = W'(i_rb);
    assign w_rc = W'(i_rc);

    // a*x + b*y = c for the A/B and B/C pairs.
    assign w_a1 = (w_xb - w_xa) <<< 1;
    assign w_b1 = (w_yb - w_ya) <<< 1;
    assign w_c1 = w_ra * w_ra - w_rb * w_rb - w_xa * w_xa + w_xb * w_xb
                - w_ya * w_ya + w_yb * w_yb;
    assign w_a2 = (w_xc - w_xb) <<< 1;
    assign w_b2 = (w_yc - w_yb) <<< 1;
    assign w_c2 = w_rb * w_rb - w_rc * w_rc - w_xb * w_xb + w_xc * w_xc
                - w_yb * w_yb + w_yc * w_yc;

    assign w_det = w_a1 * w_b2 - w_a2 * w_b1;
    assign w_xn  = w_c1 * w_b2 - w_c2 * w_b1;
    assign w_yn  = w_a1 * w_c2 - w_a2 * w_c1;

    assign o_xm = (w_det == '0) ? '0 : RW'(w_xn / w_det);
    assign o_ym = (w_det == '0) ? '0 : RW'(w_yn / w_det);
endmodule

// File: rtl/triloc_seq.sv
// triloc_seq: collects anchors A/B/C and the range word in any order,
// holds them on a TriLoc core for CALC_CYCLES cycles, registers the result
// and offers it on a valid/ready output. Slots prefetch the next job while
// a result waits for the consumer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand channels p0..p3 and result channel (slave side)
//   busy     : high in COMPUTE or OUTPUT
//   job_cnt  : completed output handshakes, wraps at 256
module triloc_seq #(
    parameter int unsigned N           = 8,
    parameter int unsigned CALC_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    triloc_seq_if.slave  bus,
    output logic         busy,
    output logic [7:0]   job_cnt
);
    localparam int unsigned CW = 2 * N;
    localparam int unsigned RW = 3 * N + 3;
    localparam int unsigned OW = 2 * N + 8;
    localparam logic [3:0]  CALC_LOAD = 4'(CALC_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [3:0]      r_full;
    logic [CW-1:0]   r_a, r_b, r_c;
    logic [RW-1:0]   r_r;
    logic [OW-1:0]   r_o_data;
    logic            r_o_valid;
    logic            r_busy;
    logic [7:0]      r_job_cnt;

    logic [3:0]      w_valid, w_ready, w_cap, w_full_nxt;
    logic            w_all_full;
    logic signed [N+3:0] w_xm, w_ym;

    // Readies: empty slot, not frozen for COMPUTE, not in reset.
    assign w_valid    = {bus.p3_valid, bus.p2_valid, bus.p1_valid, bus.p0_valid};
    assign w_ready    = (rst || r_state == COMPUTE) ? 4'b0000 : ~r_full;
    assign w_cap      = w_valid & w_ready;
    assign w_full_nxt = r_full | w_cap;
    assign w_all_full = &w_full_nxt;

    assign bus.p0_ready = w_ready[0];
    assign bus.p1_ready = w_ready[1];
    assign bus.p2_ready = w_ready[2];
    assign bus.p3_ready = w_ready[3];
    assign bus.o_valid  = r_o_valid;
    assign bus.o_data   = r_o_data;
    assign busy         = r_busy;
    assign job_cnt      = r_job_cnt;

    // Core sees the slot registers directly; sampled only at the last COMPUTE edge.
    TriLoc #(.N(N)) u_core (
        .i_xa (r_a[2*N-1:N]),
        .i_ya (r_a[N-1:0]),
        .i_xb (r_b[2*N-1:N]),
        .i_yb (r_b[N-1:0]),
        .i_xc (r_c[2*N-1:N]),
        .i_yc (r_c[N-1:0]),
        .i_ra (r_r[3*N+2:2*N+2]),
        .i_rb (r_r[2*N+1:N+1]),
        .i_rc (r_r[N:0]),
        .o_xm (w_xm),
        .o_ym (w_ym)
    );

    // Slot capture, sequencing FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_full    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_r       <= '0;
            r_o_data  <= '0;
            r_o_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_job_cnt <= '0;
        end else begin
            if (w_cap[0]) r_a <= bus.p0_data;
            if (w_cap[1]) r_b <= bus.p1_data;
            if (w_cap[2]) r_c <= bus.p2_data;
            if (w_cap[3]) r_r <= bus.p3_data;
            r_full <= w_full_nxt;

            case (r_state)
                COLLECT: begin
                    if (w_all_full) begin
                        r_state <= COMPUTE;
                        r_cnt   <= CALC_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    if (r_cnt == 4'd0) begin
                        r_o_data  <= {w_xm, w_ym};
                        r_o_valid <= 1'b1;
                        r_full    <= '0;
                        r_state   <= OUTPUT;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                OUTPUT: begin
                    if (bus.o_ready) begin
                        r_o_valid <= 1'b0;
                        r_job_cnt <= r_job_cnt + 8'd1;
                        // Prefetched job (incl. this edge's captures) starts at once.
                        if (w_all_full) begin
                            r_state <= COMPUTE;
                            r_cnt   <= CALC_LOAD;
                        end else begin
                            r_state <= COLLECT;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= COLLECT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_triloc_seq.sv
// tb_triloc_seq: directed bench for triloc_seq. u_dut runs the default
// CALC_CYCLES=2 build, u_dut1 the CALC_CYCLES=1 build. Expected results are
// hand-solved trilateration vectors.
module tb_triloc_seq;
    localparam int unsigned N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy0, busy1;
    logic [7:0] job_cnt0, job_cnt1;

    triloc_seq_if #(.N(N)) if0 ();
    triloc_seq_if #(.N(N)) if1 ();

    triloc_seq #(.N(N), .CALC_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .bus(if0), .busy(busy0), .job_cnt(job_cnt0)
    );
    triloc_seq #(.N(N), .CALC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1), .busy(busy1), .job_cnt(job_cnt1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vc [4];
    logic [26:0] vr [4];
    logic [23:0] vexp [4];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rdy0();
        return {if0.p3_ready, if0.p2_ready, if0.p1_ready, if0.p0_ready};
    endfunction

    task automatic idle();
        if0.p0_valid = 1'b0; if0.p1_valid = 1'b0; if0.p2_valid = 1'b0; if0.p3_valid = 1'b0;
        if0.p0_data = '0; if0.p1_data = '0; if0.p2_data = '0; if0.p3_data = '0;
        if0.o_ready = 1'b1;
        if1.p0_valid = 1'b0; if1.p1_valid = 1'b0; if1.p2_valid = 1'b0; if1.p3_valid = 1'b0;
        if1.p0_data = '0; if1.p1_data = '0; if1.p2_data = '0; if1.p3_data = '0;
        if1.o_ready = 1'b1;
    endtask

    // All four channels in one cycle; captured at the following edge.
    task automatic send0(input int v);
        if0.p0_valid = 1'b1; if0.p0_data = va[v];
        if0.p1_valid = 1'b1; if0.p1_data = vb[v];
        if0.p2_valid = 1'b1; if0.p2_data = vc[v];
        if0.p3_valid = 1'b1; if0.p3_data = vr[v];
        tick();
        if0.p0_valid = 1'b0; if0.p1_valid = 1'b0; if0.p2_valid = 1'b0; if0.p3_valid = 1'b0;
    endtask

    task automatic send1(input int v);
        if1.p0_valid = 1'b1; if1.p0_data = va[v];
        if1.p1_valid = 1'b1; if1.p1_data = vb[v];
        if1.p2_valid = 1'b1; if1.p2_data = vc[v];
        if1.p3_valid = 1'b1; if1.p3_data = vr[v];
        tick();
        if1.p0_valid = 1'b0; if1.p1_valid = 1'b0; if1.p2_valid = 1'b0; if1.p3_valid = 1'b0;
    endtask

    // Edges until o_valid is seen, bounded at 20.
    task automatic wait_ov(input bit sel, output int n);
        n = 0;
        while (((sel ? if1.o_valid : if0.o_valid) == 1'b0) && n < 20) begin
            tick();
            n++;
        end
    endtask

    int         n;
    logic [7:0] exp_cnt;

    initial begin
        // A{3,4} B{-5,2} C{0,-6} r{5,7,6}: det 296, x 400/296=1, y -120/296=0
        va[0] = 16'h0304; vb[0] = 16'hFB02; vc[0] = 16'h00FA;
        vr[0] = {9'd5, 9'd7, 9'd6}; vexp[0] = 24'h001000;
        // A{0,0} B{6,0} C{0,8} r{5,5,5}: point (3,4)
        va[1] = 16'h0000; vb[1] = 16'h0600; vc[1] = 16'h0008;
        vr[1] = {9'd5, 9'd5, 9'd5}; vexp[1] = 24'h003004;
        // A{-2,2} B{1,1} C{2,-6} r{5,5,5}: point (-2,-3)
        va[2] = 16'hFE02; vb[2] = 16'h0101; vc[2] = 16'h02FA;
        vr[2] = {9'd5, 9'd5, 9'd5}; vexp[2] = 24'hFFEFFD;
        // Coincident anchors: zero determinant gives {0,0}
        va[3] = 16'h0101; vb[3] = 16'h0101; vc[3] = 16'h0101;
        vr[3] = {9'd1, 9'd2, 9'd3}; vexp[3] = 24'h000000;

        rst = 1'b1;
        idle();
        repeat (3) tick();
        chk("rst_ready", 32'(rdy0()), 32'd0);
        chk("rst_ovalid", 32'(if0.o_valid), 32'd0);
        chk("rst_odata", 32'(if0.o_data), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_jobcnt", 32'(job_cnt0), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(rdy0()), 32'hF);

        // Simultaneous arrival, consumer ready.
        send0(0);
        chk("t1_ready_drop", 32'(rdy0()), 32'd0);
        chk("t1_busy", 32'(busy0), 32'd1);
        wait_ov(1'b0, n);
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_data", 32'(if0.o_data), 32'(vexp[0]));
        tick();
        chk("t1_ovalid_low", 32'(if0.o_valid), 32'd0);
        chk("t1_jobcnt", 32'(job_cnt0), 32'd1);
        chk("t1_idle", 32'(busy0), 32'd0);

        // Out-of-order arrival; p1 re-asserted with a different word.
        if0.p3_valid = 1'b1; if0.p3_data = vr[1];
        tick();
        if0.p3_valid = 1'b0;
        chk("t2_p3_full", 32'(if0.p3_ready), 32'd0);
        if0.p1_valid = 1'b1; if0.p1_data = vb[1];
        tick();
        if0.p1_data = 16'h0701;
        if0.p0_valid = 1'b1; if0.p0_data = va[1];
        tick();
        if0.p0_valid = 1'b0;
        chk("t2_p1_held", 32'(if0.p1_ready), 32'd0);
        if0.p2_valid = 1'b1; if0.p2_data = vc[1];
        tick();
        if0.p2_valid = 1'b0; if0.p1_valid = 1'b0;
        wait_ov(1'b0, n);
        chk("t2_latency", 32'(n), 32'd2);
        chk("t2_data", 32'(if0.o_data), 32'(vexp[1]));
        tick();
        chk("t2_jobcnt", 32'(job_cnt0), 32'd2);

        // Output stall with prefetch of the next job.
        if0.o_ready = 1'b0;
        send0(2);
        wait_ov(1'b0, n);
        chk("t3_latency", 32'(n), 32'd2);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                if0.p0_valid = 1'b1; if0.p0_data = va[0];
                if0.p1_valid = 1'b1; if0.p1_data = vb[0];
                if0.p2_valid = 1'b1; if0.p2_data = vc[0];
                if0.p3_valid = 1'b1; if0.p3_data = vr[0];
            end
            tick();
            if0.p0_valid = 1'b0; if0.p1_valid = 1'b0; if0.p2_valid = 1'b0; if0.p3_valid = 1'b0;
            chk("t3_stall_valid", 32'(if0.o_valid), 32'd1);
            chk("t3_stall_data", 32'(if0.o_data), 32'(vexp[2]));
        end
        chk("t3_prefetch_full", 32'(rdy0()), 32'd0);
        if0.o_ready = 1'b1;
        tick();
        chk("t3_ovalid_fall", 32'(if0.o_valid), 32'd0);
        chk("t3_busy_held", 32'(busy0), 32'd1);
        chk("t3_jobcnt", 32'(job_cnt0), 32'd3);
        wait_ov(1'b0, n);
        chk("t3_b2b_latency", 32'(n), 32'd2);
        chk("t3_b2b_data", 32'(if0.o_data), 32'(vexp[0]));
        tick();
        chk("t3_jobcnt2", 32'(job_cnt0), 32'd4);

        // 256 jobs: every result checked, counter wraps past 255.
        exp_cnt = 8'd4;
        for (int j = 0; j < 256; j++) begin
            send0(j % 4);
            wait_ov(1'b0, n);
            chk("t4_data", 32'(if0.o_data), 32'(vexp[j % 4]));
            tick();
            exp_cnt = exp_cnt + 8'd1;
            chk("t4_jobcnt", 32'(job_cnt0), 32'(exp_cnt));
            if (exp_cnt == 8'd0) chk("t4_wrap", 32'(job_cnt0), 32'd0);
        end

        // Reset during the second COMPUTE cycle.
        send0(0);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_ovalid", 32'(if0.o_valid), 32'd0);
        chk("t5_odata", 32'(if0.o_data), 32'd0);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_jobcnt", 32'(job_cnt0), 32'd0);
        chk("t5_ready_rst", 32'(rdy0()), 32'd0);
        rst = 1'b0;
        tick();
        chk("t5_slots_empty", 32'(rdy0()), 32'hF);
        if0.p0_valid = 1'b1; if0.p0_data = va[1];
        if0.p1_valid = 1'b1; if0.p1_data = vb[1];
        if0.p2_valid = 1'b1; if0.p2_data = vc[1];
        tick();
        if0.p0_valid = 1'b0; if0.p1_valid = 1'b0; if0.p2_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_ovalid", 32'(if0.o_valid), 32'd0);
            chk("t5_not_busy", 32'(busy0), 32'd0);
        end
        if0.p3_valid = 1'b1; if0.p3_data = vr[1];
        tick();
        if0.p3_valid = 1'b0;
        wait_ov(1'b0, n);
        chk("t5_latency", 32'(n), 32'd2);
        chk("t5_data", 32'(if0.o_data), 32'(vexp[1]));
        tick();
        chk("t5_jobcnt", 32'(job_cnt0), 32'd1);

        // CALC_CYCLES = 1 build.
        send1(2);
        wait_ov(1'b1, n);
        chk("t6_latency", 32'(n), 32'd1);
        chk("t6_data", 32'(if1.o_data), 32'(vexp[2]));
        tick();
        chk("t6_ovalid_low", 32'(if1.o_valid), 32'd0);
        chk("t6_jobcnt", 32'(job_cnt1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
